// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the multi-channel tick generator.
package tick_gen_pkg;

    // Per-channel control state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ch_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, active/shadow divisor+mode and the IDLE/RUN/HOLD FSM.
// New settings are written to the shadow and only become active at a period
// boundary, while idle, on re-arm from HOLD, or on sync_clr, so a period is
// never cut short.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ch_en,
    input  logic             i_sync_clr,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    input  logic             i_wr_mode,
    output logic             o_tick,
    output logic             o_wave,
    output logic             o_pending
);

    localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEF  = CNT_W'(DEF_DIV);

    // A divisor of zero behaves like one (tick every cycle)
    function automatic logic [CNT_W-1:0] f_div_eff(input logic [CNT_W-1:0] div);
        if (div == C_ZERO) begin
            f_div_eff = C_ONE;
        end else begin
            f_div_eff = div;
        end
    endfunction

    ch_state_t        r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [CNT_W-1:0] r_div, w_div_nx;
    logic             r_mode, w_mode_nx;
    logic [CNT_W-1:0] r_sdiv, w_sdiv_nx;
    logic             r_smode, w_smode_nx;
    logic             r_pending, w_pending_nx;
    logic             r_tick, w_tick_nx;
    logic             r_wave, w_wave_nx;
    logic             w_xfer;
    logic             w_tc;

    assign w_tc = (r_cnt >= (f_div_eff(r_div) - C_ONE));

    // Next-state, counter and shadow-transfer decisions
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_div_nx     = r_div;
        w_mode_nx    = r_mode;
        w_sdiv_nx    = r_sdiv;
        w_smode_nx   = r_smode;
        w_pending_nx = r_pending;
        w_tick_nx    = 1'b0;
        w_wave_nx    = r_wave;
        w_xfer       = 1'b0;

        if (i_sync_clr) begin
            w_xfer     = 1'b1;
            w_cnt_nx   = C_ZERO;
            w_wave_nx  = 1'b0;
            w_state_nx = i_ch_en ? RUN : IDLE;
        end else if (!i_ch_en) begin
            w_state_nx = IDLE;
            w_cnt_nx   = C_ZERO;
            if (r_state == IDLE) begin
                w_xfer = 1'b1;
            end else begin
                w_xfer = 1'b0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_xfer     = 1'b1;
                    w_state_nx = RUN;
                    w_cnt_nx   = C_ZERO;
                end
                RUN: begin
                    if (w_tc) begin
                        w_xfer     = 1'b1;
                        w_cnt_nx   = C_ZERO;
                        w_tick_nx  = 1'b1;
                        w_wave_nx  = ~r_wave;
                        w_state_nx = (r_mode == MODE_ONESHOT) ? HOLD : RUN;
                    end else begin
                        w_cnt_nx   = r_cnt + C_ONE;
                    end
                end
                HOLD: begin
                    w_cnt_nx = C_ZERO;
                    if (r_pending) begin
                        w_xfer     = 1'b1;
                        w_state_nx = RUN;
                    end else begin
                        w_state_nx = HOLD;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = C_ZERO;
                end
            endcase
        end

        // Transfer takes the shadow as it was before this edge's write
        if (w_xfer) begin
            w_div_nx     = r_sdiv;
            w_mode_nx    = r_smode;
            w_pending_nx = 1'b0;
        end else begin
            w_pending_nx = r_pending;
        end

        // A write on the same edge stays in shadow and keeps pending set
        if (i_wr) begin
            w_sdiv_nx    = i_wr_div;
            w_smode_nx   = i_wr_mode;
            w_pending_nx = 1'b1;
        end else begin
            w_sdiv_nx    = r_sdiv;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_cnt     <= C_ZERO;
            r_div     <= C_DEF;
            r_mode    <= MODE_PERIODIC;
            r_sdiv    <= C_DEF;
            r_smode   <= MODE_PERIODIC;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_wave    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_div     <= w_div_nx;
            r_mode    <= w_mode_nx;
            r_sdiv    <= w_sdiv_nx;
            r_smode   <= w_smode_nx;
            r_pending <= w_pending_nx;
            r_tick    <= w_tick_nx;
            r_wave    <= w_wave_nx;
        end
    end

    assign o_tick    = r_tick;
    assign o_wave    = r_wave;
    assign o_pending = r_pending;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable clock-enable generator: decodes writes to
// per-channel strobes and replicates tick_channel NUM_CH times.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 32,
    parameter  int DEF_DIV = 100,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic              wr_mode,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] wave,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] w_wr;

    // Write strobe decode; an index with no channel selects nothing
    always_comb begin
        w_wr = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (int'(wr_ch) == i)) begin
                w_wr[i] = 1'b1;
            end else begin
                w_wr[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_ch_en    (ch_en[g]),
            .i_sync_clr (sync_clr),
            .i_wr       (w_wr[g]),
            .i_wr_div   (wr_div),
            .i_wr_mode  (wr_mode),
            .o_tick     (tick[g]),
            .o_wave     (wave[g]),
            .o_pending  (pending[g])
        );
    end

endmodule
